debounce_bank: RTL and testbench
================================

// Module: debounce_bank
// PURPOSE
//   Multi-channel successor to the single-input debouncer: CHANNELS raw button/switch pins,
//   each synchronised, debounced, polarity-corrected, with one-cycle press/release/long-press
//   pulses. Sits between board pins and the control FSMs, replacing per-button instances.
// PARAMETERS
//   CHANNELS     4        number of independent input channels (>=1)
//   DELAY        400_000  consecutive clk cycles an input must differ from state to commit (>=1)
//   SYNC_STAGES  2        flip-flop synchroniser depth per channel (>=2)
//   ACTIVE_LOW   0        per-channel bitmask [CHANNELS-1:0]; bit=1 inverts that raw pin
//   HOLD_CYCLES  0        cycles of continuous pressed state before long_press; 0 disables
// PORTS
//   clk          in   1          system clock
//   rst_n        in   1          asynchronous active-low reset
//   btn_raw      in   CHANNELS   raw asynchronous pins
//   btn_state    out  CHANNELS   debounced level, 1 = pressed
//   btn_press    out  CHANNELS   1-cycle pulse on 0->1 commit of btn_state
//   btn_release  out  CHANNELS   1-cycle pulse on 1->0 commit of btn_state
//   btn_long     out  CHANNELS   1-cycle pulse when pressed for HOLD_CYCLES
// BEHAVIOUR
//   - Reset (async assert, sync-to-clk deassert not required here): sync flops load the
//     inactive pin level (1 if ACTIVE_LOW bit set, else 0); counters 0; all outputs 0.
//     No press/release pulse may follow reset release while the pin is at inactive level.
//   - Per channel: s = synchronised pin XOR ACTIVE_LOW[i]; pin-to-s latency SYNC_STAGES cycles.
//   - Debounce counter cnt, width $clog2(DELAY+1): if s==btn_state, cnt<=0. Else if
//     cnt==DELAY-1, btn_state<=s, cnt<=0; else cnt<=cnt+1. Commit therefore happens on the
//     DELAY-th consecutive differing sample; total pin-to-state latency SYNC_STAGES+DELAY.
//   - Any single sample with s==btn_state clears cnt (glitch rejection); no hysteresis beyond that.
//   - btn_press/btn_release are registered, asserted in the same cycle btn_state changes,
//     for exactly one cycle; never both in one cycle for one channel.
//   - Hold counter (only if HOLD_CYCLES>0), width $clog2(HOLD_CYCLES+1): cleared while
//     btn_state==0; increments while btn_state==1, saturating at HOLD_CYCLES. btn_long
//     pulses once, on the cycle the counter reaches HOLD_CYCLES; no repeat until a release.
//     The cycle of press commit counts as hold cycle 1. HOLD_CYCLES==0: btn_long tied 0, no logic.
//   - Channels fully independent; simultaneous commits on several channels are all reported
//     the same cycle. DELAY==1: state follows s with one-cycle register delay.
//   - rst_n asserted mid-count or mid-hold: all state discarded, no pulses emitted.
//   - Counters never wrap: debounce cnt bounded by DELAY-1, hold counter saturates.
// STRUCTURE
//   - Shared package debounce_pkg: cnt_width(n) function ($clog2(n+1)), default DELAY constants
//     for 100 MHz board clock (4 ms = 400_000), ACTIVE_LOW mask constant for the board buttons.
//   - One sub-module debounce_channel (synchroniser + debounce cnt + hold cnt + pulse regs),
//     instantiated CHANNELS times via generate; top only slices buses and ACTIVE_LOW bits.
// TESTING  (bench params: CHANNELS=4, DELAY=8, SYNC_STAGES=2, HOLD_CYCLES=20, ACTIVE_LOW=4'b1000)
//   - Reset: hold rst_n=0 with btn_raw=4'b1000 -> all outputs 0; release -> no pulses for 50 cycles.
//   - Clean press ch0: btn_raw[0] 0->1 and held -> btn_state[0]=1 and btn_press[0]=1 exactly
//     10 cycles after the edge is sampled; btn_press[0] high for 1 cycle only.
//   - Glitch: ch1 high 7 cycles, low 1, high 7, low -> btn_state[1] never changes, no pulses.
//   - Long press ch2: hold 40 cycles -> btn_long[2] single pulse 19 cycles after btn_press[2];
//     release -> btn_release[2] pulse, btn_long stays 0; re-press 40 cycles -> second btn_long.
//   - Active-low ch3: btn_raw[3] 1->0 held -> btn_press[3]; 0->1 -> btn_release[3] after 10 cycles.
//   - Simultaneous + reset mid-op: ch0,ch1 pressed same cycle -> both pulses same cycle; assert
//     rst_n after 5 cycles of a new change -> outputs 0 immediately (async), no pulse after release.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the button debounce bank.
// Defaults target the 100 MHz board clock and its four front-panel buttons.
package debounce_pkg;

  localparam int BOARD_CLK_HZ     = 100_000_000;
  localparam int DEBOUNCE_MS      = 4;
  localparam int DELAY_4MS_100MHZ = (BOARD_CLK_HZ / 1000) * DEBOUNCE_MS;

  // Button 3 on the board is wired to ground when pressed.
  localparam int                        BOARD_BUTTONS    = 4;
  localparam logic [BOARD_BUTTONS-1:0]  BOARD_ACTIVE_LOW = 4'b1000;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: synchroniser, polarity fix, debounce counter,
// optional hold counter and registered press/release/long pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DELAY       = DELAY_4MS_100MHZ,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 0,
  parameter bit INV         = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic state,
  output logic press,
  output logic rel,
  output logic long_press
);

  localparam int             CW       = cnt_width(DELAY);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DELAY - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   state_nxt;

  // Sync flops reset to the idle pin level so release from reset looks quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {SYNC_STAGES{INV}};
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
  end

  assign s = sync_q[SYNC_STAGES-1] ^ INV;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (s == state) begin
      cnt_nxt = '0;
    end else if (cnt == CNT_LAST) begin
      state_nxt = s;
      cnt_nxt   = '0;
    end else begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      press <= state_nxt & ~state;
      rel   <= ~state_nxt & state;
    end
  end

  if (HOLD_CYCLES > 0) begin : g_hold
    localparam int            HW       = cnt_width(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_PRE = HW'(HOLD_CYCLES - 1);

    logic [HW-1:0] hold_cnt;

    // Keyed off state_nxt so the press-commit cycle is already hold cycle 1.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_cnt   <= '0;
        long_press <= 1'b0;
      end else begin
        long_press <= state_nxt && (hold_cnt == HOLD_PRE);
        if (!state_nxt)                hold_cnt <= '0;
        else if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end else begin : g_no_hold
    assign long_press = 1'b0;
  end

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounced button channels; slices the pin bus
// and per-channel polarity bits onto debounce_channel instances.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int                  CHANNELS    = 4,
  parameter int                  DELAY       = DELAY_4MS_100MHZ,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW  = '0,
  parameter int                  HOLD_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn_raw,
  output logic [CHANNELS-1:0] btn_state,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] btn_long
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .DELAY       (DELAY),
      .SYNC_STAGES (SYNC_STAGES),
      .HOLD_CYCLES (HOLD_CYCLES),
      .INV         (ACTIVE_LOW[i])
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .pin        (btn_raw[i]),
      .state      (btn_state[i]),
      .press      (btn_press[i]),
      .rel        (btn_release[i]),
      .long_press (btn_long[i])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Randomised + directed bench for debounce_bank: a window-based reference model
// queues expected outputs per clock, a negedge monitor pops and compares.
module tb_debounce_bank;

  localparam int             CH   = 4;
  localparam int             DLY  = 8;
  localparam int             SS   = 2;
  localparam int             HOLD = 20;
  localparam logic [CH-1:0]  AL   = 4'b1000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] btn_raw = AL;
  logic [CH-1:0] btn_state, btn_press, btn_release, btn_long;

  debounce_bank #(
    .CHANNELS(CH), .DELAY(DLY), .SYNC_STAGES(SS), .ACTIVE_LOW(AL), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .btn_state(btn_state), .btn_press(btn_press),
    .btn_release(btn_release), .btn_long(btn_long)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0] st;
    logic [CH-1:0] pr;
    logic [CH-1:0] rl;
    logic [CH-1:0] lg;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: pin history, debounced level, length of current pressed run.
  logic [CH-1:0] hist[$];
  logic [CH-1:0] m_state;
  int            run[CH];

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < SS + DLY; i++) hist.push_back(AL);
    m_state = '0;
    for (int c = 0; c < CH; c++) run[c] = 0;
  endfunction

  // Async reset clears whatever the model expected for the current cycle.
  always @(negedge rst_n) begin
    model_reset();
    if (exp_q.size() > 0) exp_q[exp_q.size()-1] = '0;
  end

  always @(posedge clk) begin
    obs_t o;
    o = '0;
    if (!rst_n) begin
      model_reset();
    end else begin
      hist.push_front(btn_raw);
      void'(hist.pop_back());
      for (int c = 0; c < CH; c++) begin
        bit all_diff;
        all_diff = 1'b1;
        // State flips once the last DLY synchronised samples all disagree with it.
        for (int j = 0; j < DLY; j++) begin
          logic [CH-1:0] h;
          h = hist[SS + j];
          if ((h[c] ^ AL[c]) == m_state[c]) all_diff = 1'b0;
        end
        if (all_diff) begin
          m_state[c] = ~m_state[c];
          if (m_state[c]) o.pr[c] = 1'b1;
          else            o.rl[c] = 1'b1;
        end
        run[c]  = m_state[c] ? run[c] + 1 : 0;
        o.lg[c] = (run[c] == HOLD);
      end
      o.st = m_state;
    end
    exp_q.push_back(o);
  end

  always @(negedge clk) begin
    obs_t want, got;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = {btn_state, btn_press, btn_release, btn_long};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL outputs t=%0t got st=%b pr=%b rl=%b lg=%b want st=%b pr=%b rl=%b lg=%b",
                 $time, got.st, got.pr, got.rl, got.lg, want.st, want.pr, want.rl, want.lg);
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Counts clock edges until the chosen pulse (0 press, 1 release, 2 long) is seen.
  task automatic measure(input string name, input int ch, input int kind,
                         input int want, input int limit);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < limit) begin
      @(posedge clk);
      #1;
      n++;
      case (kind)
        0:       seen = btn_press[ch];
        1:       seen = btn_release[ch];
        default: seen = btn_long[ch];
      endcase
    end
    total++;
    if (!seen || n != want) begin
      bad++;
      $display("FAIL %s latency got=%0d want=%0d", name, seen ? n : -1, want);
    end
  endtask

  initial begin
    // Reset with ch3 idle-high, then 50 quiet cycles.
    rst_n   = 1'b0;
    btn_raw = AL;
    tick(5);
    rst_n = 1'b1;
    tick(50);

    // Clean press on ch0.
    btn_raw[0] = 1'b1;
    measure("ch0_press", 0, 0, SS + DLY, 40);
    tick(30);
    btn_raw[0] = 1'b0;
    measure("ch0_release", 0, 1, SS + DLY, 40);
    tick(10);

    // Glitch on ch1: never DLY consecutive samples.
    btn_raw[1] = 1'b1; tick(7);
    btn_raw[1] = 1'b0; tick(1);
    btn_raw[1] = 1'b1; tick(7);
    btn_raw[1] = 1'b0; tick(20);
    total++;
    if (btn_state[1] !== 1'b0) begin
      bad++;
      $display("FAIL glitch_ch1 got=%b want=0", btn_state[1]);
    end

    // Long press on ch2, release, then again.
    for (int r = 0; r < 2; r++) begin
      btn_raw[2] = 1'b1;
      measure("ch2_press", 2, 0, SS + DLY, 40);
      measure("ch2_long", 2, 2, HOLD - 1, 60);
      tick(25);
      btn_raw[2] = 1'b0;
      measure("ch2_release", 2, 1, SS + DLY, 40);
      tick(20);
    end

    // Active-low ch3.
    btn_raw[3] = 1'b0;
    measure("ch3_press", 3, 0, SS + DLY, 40);
    tick(15);
    btn_raw[3] = 1'b1;
    measure("ch3_release", 3, 1, SS + DLY, 40);
    tick(10);

    // Simultaneous press on ch0/ch1, then reset mid-count.
    btn_raw[1:0] = 2'b11;
    measure("ch01_press", 0, 0, SS + DLY, 40);
    total++;
    if (btn_press[1] !== 1'b1) begin
      bad++;
      $display("FAIL ch1_same_cycle got=%b want=1", btn_press[1]);
    end
    tick(12);
    btn_raw[1:0] = 2'b00;
    tick(5);
    rst_n = 1'b0;
    #1;
    total++;
    if ({btn_state, btn_press, btn_release, btn_long} !== '0) begin
      bad++;
      $display("FAIL async_reset got=%h want=0", {btn_state, btn_press, btn_release, btn_long});
    end
    tick(3);
    rst_n = 1'b1;
    tick(30);

    // Random pin activity with occasional resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 7) == 0) btn_raw[c] = ~btn_raw[c];
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
      end
      tick(1);
    end
    btn_raw = AL;
    tick(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
